// File: rtl/ex_muldiv_stage.sv
// EX stage with a single-cycle ALU and an iterative 32-cycle unsigned multiply/divide unit.
// Results feed the EX/MEM output register; HI/LO are written when a mul/div retires.
module ex_muldiv_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] Imm,
  input  logic        AluSrc,
  input  logic [3:0]  AluOp,
  input  logic [4:0]  Shamt,
  input  logic        MemtoRegIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteRegIn,
  output logic        Stall,
  output logic [31:0] AluResult,
  output logic [31:0] ReadData2Out,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic        Zero,
  output logic        OutValid
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] acc_q, acc_d, wlo_q, wlo_d, opb_q, opb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [31:0] res_q, res_d, rd2_q, rd2_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [4:0]  wr_q, wr_d;
  logic        vld_q, vld_d, zero_q;

  logic [31:0] op_b, alu;
  logic        is_md, accept, stall_c;
  logic [32:0] mul_sum, div_sh, div_tr;

  assign op_b    = AluSrc ? Imm : ReadData2;
  assign is_md   = (AluOp == 4'd11) || (AluOp == 4'd12);
  assign accept  = (state_q == S_IDLE) && InValid && is_md;
  assign stall_c = accept || (state_q == S_BUSY);
  assign Stall   = !Reset && stall_c;

  // acc holds product-high / remainder, wlo holds multiplier / dividend-becoming-quotient
  assign mul_sum = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_sh  = {acc_q, wlo_q[31]};
  assign div_tr  = div_sh - {1'b0, opb_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    wlo_d    = wlo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_BUSY;
        cnt_d    = 5'd0;
        is_div_d = (AluOp == 4'd12);
        acc_d    = 32'd0;
        wlo_d    = (AluOp == 4'd12) ? ReadData1 : op_b;
        opb_d    = (AluOp == 4'd12) ? op_b : ReadData1;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          // no borrow means the divisor fits: keep the difference, quotient bit 1
          if (!div_tr[32]) begin
            acc_d = div_tr[31:0];
            wlo_d = {wlo_q[30:0], 1'b1};
          end else begin
            acc_d = div_sh[31:0];
            wlo_d = {wlo_q[30:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[32:1];
          wlo_d = {mul_sum[0], wlo_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = acc_q;
        lo_d    = wlo_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu = 32'd0;
    case (AluOp)
      4'd0:  alu = ReadData1 & op_b;
      4'd1:  alu = ReadData1 | op_b;
      4'd2:  alu = ReadData1 + op_b;
      4'd3:  alu = ReadData1 - op_b;
      4'd4:  alu = {31'd0, $signed(ReadData1) < $signed(op_b)};
      4'd5:  alu = {31'd0, ReadData1 < op_b};
      4'd6:  alu = ~(ReadData1 | op_b);
      4'd7:  alu = ReadData1 ^ op_b;
      4'd8:  alu = op_b << Shamt;
      4'd9:  alu = op_b >> Shamt;
      4'd10: alu = $unsigned($signed(op_b) >>> Shamt);
      4'd13: alu = hi_q;
      4'd14: alu = lo_q;
      4'd15: alu = op_b << 16;
      default: alu = 32'd0;
    endcase
  end

  // retiring mul/div writes nothing to the register file; stalls and idle cycles are bubbles
  always_comb begin
    res_d = 32'd0;
    rd2_d = 32'd0;
    ctl_d = 4'd0;
    wr_d  = 5'd0;
    vld_d = 1'b0;
    if (state_q == S_DONE) begin
      vld_d = 1'b1;
    end else if (!stall_c && InValid) begin
      res_d = alu;
      rd2_d = ReadData2;
      ctl_d = {MemtoRegIn, MemReadIn, MemWriteIn, RegWriteIn};
      wr_d  = WriteRegIn;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      acc_q    <= 32'd0;
      wlo_q    <= 32'd0;
      opb_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_q    <= 32'd0;
      rd2_q    <= 32'd0;
      ctl_q    <= 4'd0;
      wr_q     <= 5'd0;
      vld_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      wlo_q    <= wlo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      rd2_q    <= rd2_d;
      ctl_q    <= ctl_d;
      wr_q     <= wr_d;
      vld_q    <= vld_d;
      zero_q   <= (res_d == 32'd0);
    end
  end

  assign AluResult    = res_q;
  assign ReadData2Out = rd2_q;
  assign {MemtoReg, MemRead, MemWrite, RegWrite} = ctl_q;
  assign WriteReg     = wr_q;
  assign Zero         = zero_q;
  assign OutValid     = vld_q;
endmodule
